// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline hazard controller beside the decode-stage
// forwarding logic. Detects load-use, taken-branch and multi-cycle mul/div
// occupancy and drives the stage enable, bubble and flush strobes. Keeps a
// saturating count of cycles in which the PC was held.
//
// Optional feature macro: HAZARD_SEQ_MULDIV_EN
//   defined   -> MD_BUSY state, md_cnt down-counter and mul/div stalling built
//   undefined -> ExMulDivStart ignored, FSM never leaves RUN, Busy stays 0,
//                EXMEMBubble is 0 outside reset

module hazard_sequencer #(
    parameter int MULDIV_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [0:5]       DecRs1,
    input  logic [0:5]       DecRs2,
    input  logic             DecUsesRs1,
    input  logic             DecUsesRs2,
    input  logic [0:5]       ExRd,
    input  logic             ExIsLoad,
    input  logic             ExBranchTaken,
    input  logic             ExMulDivStart,
    output logic             PCWe,
    output logic             IFIDWe,
    output logic             IFIDFlush,
    output logic             IDEXWe,
    output logic             IDEXBubble,
    output logic             EXMEMBubble,
    output logic             Busy,
    output logic [0:CNT_W-1] StallCount
);

`ifdef HAZARD_SEQ_MULDIV_EN
    localparam logic MULDIV_EN = 1'b1;
`else
    localparam logic MULDIV_EN = 1'b0;
`endif

    localparam logic [3:0]       MD_LOAD  = 4'(MULDIV_CYCLES - 2);
    localparam logic [0:CNT_W-1] CNT_MAX  = '1;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    state_t            r_state;
    logic [3:0]        r_mdCnt;
    logic [0:CNT_W-1]  r_stallCount;

    logic              w_loadUse;
    logic              w_mdStart;

    // Hazard qualifiers; register 0 never creates a dependency and the
    // mul/div start is masked off entirely when that feature is not built.
    always_comb begin
        w_loadUse = ExIsLoad && (ExRd != 6'd0) &&
                    ((DecUsesRs1 && (DecRs1 == ExRd)) ||
                     (DecUsesRs2 && (DecRs2 == ExRd)));
        w_mdStart = MULDIV_EN && ExMulDivStart;
    end

    // Mealy stage-control strobes: reset forces everything safe, then
    // occupancy > mul/div start > taken branch > load-use.
    always_comb begin
        PCWe        = 1'b1;
        IFIDWe      = 1'b1;
        IFIDFlush   = 1'b0;
        IDEXWe      = 1'b1;
        IDEXBubble  = 1'b0;
        EXMEMBubble = 1'b0;
        Busy        = 1'b0;
        if (rst) begin
            PCWe        = 1'b0;
            IFIDWe      = 1'b0;
            IDEXWe      = 1'b0;
            IFIDFlush   = 1'b1;
            IDEXBubble  = 1'b1;
            EXMEMBubble = 1'b1;
        end else if (r_state == MD_BUSY) begin
            PCWe        = 1'b0;
            IFIDWe      = 1'b0;
            IDEXWe      = 1'b0;
            EXMEMBubble = 1'b1;
            Busy        = 1'b1;
        end else if (w_mdStart) begin
            PCWe        = 1'b0;
            IFIDWe      = 1'b0;
            IDEXWe      = 1'b0;
            EXMEMBubble = 1'b1;
        end else if (ExBranchTaken) begin
            IFIDFlush   = 1'b1;
            IDEXBubble  = 1'b1;
        end else if (w_loadUse) begin
            PCWe        = 1'b0;
            IFIDWe      = 1'b0;
            IDEXBubble  = 1'b1;
        end
    end

    // Occupancy FSM: the start cycle is the first stall, then md_cnt runs
    // from MULDIV_CYCLES-2 down to 0 in MD_BUSY; new starts there are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_mdCnt <= 4'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mdStart) begin
                        r_state <= MD_BUSY;
                        r_mdCnt <= MD_LOAD;
                    end
                end
                MD_BUSY: begin
                    if (r_mdCnt == 4'd0) begin
                        r_state <= RUN;
                    end else begin
                        r_mdCnt <= r_mdCnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_mdCnt <= 4'd0;
                end
            endcase
        end
    end

    // Performance counter of PC-hold cycles, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCount <= '0;
        end else if (!PCWe && (r_stallCount != CNT_MAX)) begin
            r_stallCount <= r_stallCount + CNT_W'(1);
        end
    end

    assign StallCount = r_stallCount;

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline hazard controller sitting beside the decode-stage forwarding logic. It detects the cases forwarding cannot cover (load-use, taken-branch redirect, multi-cycle multiply/divide occupancy) and drives the stage write-enable, bubble and flush strobes for IF, IF/ID, ID/EX and EX/MEM. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
- `MULDIV_CYCLES`, default 4: total EX occupancy of a mul/div op in cycles; legal range 2..15.
- `CNT_W`, default 16: width of the stall counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `DecRs1`, `DecRs2`  in  [0:5]  source registers of the instruction in DEC.
- `DecUsesRs1`, `DecUsesRs2`  in  1  the DEC instruction actually reads that source.
- `ExRd`  in  [0:5]  destination of the instruction in EX.
- `ExIsLoad`  in  1  the EX instruction is a load.
- `ExBranchTaken`  in  1  the EX instruction is a resolved, taken branch or jump.
- `ExMulDivStart`  in  1  the EX instruction is a mul/div and this is its first EX cycle.
- `PCWe`  out  1  PC update enable.
- `IFIDWe`  out  1  IF/ID register load enable.
- `IFIDFlush`  out  1  IF/ID register loads a NOP.
- `IDEXWe`  out  1  ID/EX register load enable.
- `IDEXBubble`  out  1  ID/EX register loads a NOP.
- `EXMEMBubble`  out  1  EX/MEM register loads a NOP.
- `Busy`  out  1  mul/div occupancy in progress.
- `StallCount`  out  [0:CNT_W-1]  saturating count of cycles with `PCWe`=0.

## Operation
- States: RUN and MD_BUSY. Down-counter `md_cnt` is 4 bits wide.
- Load-use hazard, evaluated only in RUN: `ExIsLoad` & `ExRd`≠0 & ((`DecUsesRs1` & `DecRs1`==`ExRd`) | (`DecUsesRs2` & `DecRs2`==`ExRd`)).
  - Response: `PCWe`=0, `IFIDWe`=0, `IDEXBubble`=1. This is Mealy behaviour in the same cycle.
  - The bubble moves the load to MEM, so the next cycle is resolved by MEM forwarding.
- Taken branch, evaluated only in RUN: `IFIDFlush`=1 and `IDEXBubble`=1; `PCWe`=1 so the PC takes the target.
- Priority within a RUN cycle is `ExMulDivStart` > `ExBranchTaken` > load-use.
  - A branch taken in the same cycle suppresses the load-use stall response.
- Mul/div, RUN with `ExMulDivStart`=1:
  - Same cycle: `PCWe`, `IFIDWe` and `IDEXWe` are 0, and `EXMEMBubble`=1.
  - Next state is MD_BUSY with `md_cnt`=`MULDIV_CYCLES`-2.
- MD_BUSY:
  - Holds the same stall outputs and drives `Busy`=1. `ExBranchTaken`, `ExMulDivStart` and load-use are ignored.
  - `md_cnt` decrements each cycle. The cycle with `md_cnt`==0 is the last stall cycle; next state is RUN.
  - In the following RUN cycle all enables are 1 and the op's result is written to EX/MEM.
- Default RUN outputs with no hazard: every enable is 1; every bubble, flush and `Busy` is 0.
- `StallCount` increments by 1 on every edge where `PCWe`=0. It saturates at all-ones and does not wrap.

## Timing
- Reset (`rst`=1 at an edge):
  - State becomes RUN, `md_cnt`=0, `StallCount`=0.
  - While `rst` is high, combinational outputs are forced: `PCWe`=`IFIDWe`=`IDEXWe`=0, `IFIDFlush`=`IDEXBubble`=`EXMEMBubble`=1, `Busy`=0.
  - `StallCount` does not count reset cycles.
- Reset in MD_BUSY aborts the op immediately. The first post-reset cycle is RUN.
- Load-use costs exactly 1 stall cycle. A taken branch costs 2 flushed slots and 0 stall cycles.
- A mul/div costs exactly `MULDIV_CYCLES` stall cycles, counted from the `ExMulDivStart` cycle inclusive. `Busy` is high for `MULDIV_CYCLES`-1 cycles.
- `ExMulDivStart` sampled in MD_BUSY is ignored, not queued.

## Configuration
- `HAZARD_SEQ_MULDIV_EN` defined: the MD_BUSY state, `md_cnt` and mul/div stalling are built as described.
- Not defined:
  - `ExMulDivStart` is ignored, the FSM stays in RUN, and `Busy` is tied to 0.
  - `EXMEMBubble` is tied to 0 outside reset.
  - Load-use and branch behaviour are unchanged.

## Test plan
- Load-use: `ExIsLoad`=1, `ExRd`=5, `DecRs1`=5, `DecUsesRs1`=1 for 1 cycle -> that cycle `PCWe`=0, `IFIDWe`=0, `IDEXBubble`=1; `StallCount` goes 0->1; the next cycle has all enables at 1.
- Register 0 and unused source:
  - `ExRd`=0 with `DecRs1`=0 -> no stall.
  - `ExRd`=7, `DecRs2`=7, `DecUsesRs2`=0 -> no stall.
- Branch plus load-use together: `ExBranchTaken`=1 in the same cycle as a load-use match -> `IFIDFlush`=1, `IDEXBubble`=1, `PCWe`=1; `StallCount` unchanged.
- Mul/div with `MULDIV_CYCLES`=4: a 1-cycle `ExMulDivStart` pulse -> `PCWe`=0 for 4 consecutive cycles and `Busy`=1 for the last 3; `EXMEMBubble`=1 for all 4; `StallCount`=4; `ExBranchTaken` pulsed during MD_BUSY has no effect.
- Reset mid-op: assert `rst` in the 2nd MD_BUSY cycle -> `Busy`=0 and `StallCount`=0 after the edge; with `rst` low the next cycle shows RUN defaults.
- Saturation with `CNT_W`=4: 20 consecutive load-use cycles -> `StallCount` holds at 15.
